// File: rtl/dmem_io_responder.sv
// Data-side responder for the RV32 core: word RAM plus an IO page (LEDs, cycle counter, UART TX).
// The IO page is selected by Address[22]. Loads are combinational and stores take effect on the clock edge.
module dmem_io_responder #(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter string       INIT_FILE    = "",
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [31:0] leds,
    output logic        uart_tx
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          io_sel;
    logic [2:0]    io_off;
    logic          ram_we, leds_we, push_req, status_we;

    assign ram_idx   = Address[AW+1:2];
    assign io_sel    = Address[22];
    assign io_off    = Address[4:2];
    assign ram_we    = MemWrite & ~io_sel;
    assign leds_we   = MemWrite & io_sel & (io_off == 3'd0);
    assign push_req  = MemWrite & io_sel & (io_off == 3'd1);
    assign status_we = MemWrite & io_sel & (io_off == 3'd2);

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_idx] <= WriteData;
    end

    logic [31:0] leds_q, cycles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_q   <= '0;
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
            if (leds_we) leds_q <= WriteData;
        end
    end

    assign leds = leds_q;

    // TX FIFO
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q;
    logic          fifo_full, fifo_empty, pop, push_ok;
    tx_state_e     state_q, state_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = (state_q == StIdle) & ~fifo_empty;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push_ok    = push_req & (~fifo_full | pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_q[wr_ptr_q] <= WriteData[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (status_we)                overflow_q <= 1'b0;
            else if (push_req & ~push_ok) overflow_q <= 1'b1;
        end
    end

    // UART serializer
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          baud_done;

    assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StStart;
                    baud_d  = '0;
                    shift_d = fifo_q[rd_ptr_q];
                end
            end
            StStart: begin
                if (baud_done) begin
                    state_d = StData;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_done) begin
                    state_d = StIdle;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Decoded from state so reset forces the line high without waiting for an edge.
    assign uart_tx = (state_q == StStart) ? 1'b0 :
                     (state_q == StData)  ? shift_q[0] : 1'b1;

    logic [3:0]  cnt_ext;
    logic [31:0] status;

    assign cnt_ext = 4'(count_q);
    assign status  = {25'b0, cnt_ext[2:0], overflow_q, fifo_empty, fifo_full,
                      (state_q != StIdle)};

    always_comb begin
        ReadData = '0;
        if (io_sel) begin
            case (io_off)
                3'd0:    ReadData = leds_q;
                3'd2:    ReadData = status;
                3'd3:    ReadData = cycles_q;
                default: ReadData = '0;
            endcase
        end else begin
            ReadData = mem[ram_idx];
        end
    end

    logic unused_bits;
    assign unused_bits = ^{Address[31:23], Address[21:5], Address[1:0], WriteData[31:8],
                           cnt_ext[3]};

endmodule

// File: tb/tb_dmem_io_responder.sv
// Scoreboard bench for dmem_io_responder: loads/LEDs checked by a negedge monitor,
// UART frames decoded by a serial receiver and compared against the expected-byte queue.
module tb_dmem_io_responder;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WORDS = 1024;

    localparam logic [31:0] A_LEDS   = 32'h0040_0000;
    localparam logic [31:0] A_UDATA  = 32'h0040_0004;
    localparam logic [31:0] A_STATUS = 32'h0040_0008;
    localparam logic [31:0] A_CYCLES = 32'h0040_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] ReadData, leds;
    logic        uart_tx;

    always #5 clk = ~clk;

    dmem_io_responder #(
        .MEM_WORDS(WORDS),
        .INIT_FILE(""),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Address(Address),
        .WriteData(WriteData),
        .MemWrite(MemWrite),
        .ReadData(ReadData),
        .leds(leds),
        .uart_tx(uart_tx)
    );

    typedef struct {
        int          sel;   // 0 ReadData, 1 leds, 2 uart_tx
        logic [31:0] exp;
        string       nm;
    } item_t;

    item_t       sb_q[$];
    logic [7:0]  byte_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          rx_frames = 0;
    logic [31:0] tb_cyc;

    // Reference cycle count: zero in the first cycle after reset, +1 per edge.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cyc <= '0;
        else       tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int sel, input logic [31:0] e, input string nm);
        sb_q.push_back('{sel, e, nm});
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        Address  = a;
        MemWrite = 1'b0;
        sb_q.push_back('{0, e, nm});
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    item_t it;
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.sel)
                0:       check(it.nm, ReadData, it.exp);
                1:       check(it.nm, leds, it.exp);
                default: check(it.nm, {31'b0, uart_tx}, it.exp);
            endcase
        end
    end

    // Serial receiver: mid-bit sampling on negedges, abandons a frame cut by reset.
    initial begin : rx
        logic [7:0] data;
        logic       aborted, st, sp;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                aborted = 1'b0;
                data    = '0;
                repeat (2) begin
                    @(negedge clk);
                    if (reset) aborted = 1'b1;
                end
                st = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin
                        @(negedge clk);
                        if (reset) aborted = 1'b1;
                    end
                    data[i] = uart_tx;
                end
                repeat (CPB) begin
                    @(negedge clk);
                    if (reset) aborted = 1'b1;
                end
                sp = uart_tx;
                if (!aborted) begin
                    rx_frames++;
                    check("rx_start_bit", {31'b0, st}, 32'd0);
                    check("rx_stop_bit", {31'b0, sp}, 32'd1);
                    if (byte_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL rx_unexpected_frame: got 0x%02h expected no frame", data);
                    end else begin
                        check("rx_byte", {24'b0, data}, {24'b0, byte_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time %0t reached limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] b;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        expect_sig(1, 32'h0, "reset_leds");
        expect_sig(2, 32'h1, "reset_uart_tx");
        rd(A_CYCLES, 32'h0, "cycles_first");
        rd(A_STATUS, 32'h4, "reset_status");

        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
        rd(32'h10 + 4 * WORDS, 32'hDEAD_BEEF, "ram_alias");
        rd(32'h0040_0010, 32'h0, "io_off4_rd");
        wr(A_CYCLES, 32'h1234_5678);
        rd(A_CYCLES, tb_cyc, "cycles_readonly");

        wr(A_LEDS, 32'hA5);
        expect_sig(1, 32'hA5, "leds_out");
        rd(A_LEDS, 32'hA5, "leds_rd");
        rd(A_UDATA, 32'h0, "uart_data_rd");

        // Single 0x55 frame: queued one cycle, then START with FIFO empty again.
        byte_q.push_back(8'h55);
        wr(A_UDATA, 32'h55);
        rd(A_STATUS, 32'h10, "status_queued");
        expect_sig(2, 32'h0, "tx_start_low");
        rd(A_STATUS, 32'h5, "status_busy");
        idle(42);
        rd(A_STATUS, 32'h4, "status_idle1");

        // Six back-to-back pushes into depth 4: first pops at once, sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            b = 8'((i + 1) * 17);
            if (i < 5) byte_q.push_back(b);
            wr(A_UDATA, {24'b0, b});
        end
        rd(A_STATUS, 32'h4B, "status_overflow");
        wr(A_STATUS, 32'h0);
        rd(A_STATUS, 32'h43, "status_ovf_cleared");
        idle(230);
        rd(A_STATUS, 32'h4, "status_idle2");

        rd(A_CYCLES, tb_cyc, "cycles_a");
        idle(9);
        rd(A_CYCLES, tb_cyc, "cycles_b");

        // Reset during the start bit of a frame.
        wr(A_UDATA, 32'hA7);
        step();
        reset = 1'b1;
        expect_sig(2, 32'h1, "reset_mid_uart_tx");
        step();
        step();
        reset = 1'b0;
        expect_sig(2, 32'h1, "post_reset_uart_tx");
        rd(A_STATUS, 32'h4, "post_reset_status");
        idle(45);

        check("rx_frame_count", rx_frames, 32'd6);
        check("rx_bytes_left", byte_q.size(), 32'd0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
